unified_mem_arbiter: RTL and testbench

//  Shares one single-ported memory bus between the IF-stage instruction fetch and the MEM-stage load/store unit.

---
 rtl/riscv_mem_defs.sv | 31 +++
 rtl/mem_arb_prio.sv | 54 +++++
 rtl/unified_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_defs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : riscv_mem_defs                                                   |
// | Purpose : Shared definitions for the unified memory arbiter: FSM state     |
// |           codes, transaction owner codes and a counter-width helper.       |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package riscv_mem_defs;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Which requester owns the in-flight bus transaction
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } arb_owner_t;

    // Bits needed to count 0..max_cnt (at least one bit)
    function automatic int unsigned starve_cnt_w(input int unsigned max_cnt);
        return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mem_arb_prio                                                     |
// | Purpose : Combinational LS-over-IF priority select with an anti-starvation |
// |           counter that forces an IF grant after STARVE_MAX consecutive LS  |
// |           grants taken while IF was waiting.                               |
// | Ports   : clk, rstn        clock / async active-low reset                  |
// |           arb_en           arbitration window (arbiter idle)               |
// |           if_req, ls_req   requests                                        |
// |           gnt_if, gnt_ls   one-hot grants, valid only while arb_en         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mem_arb_prio
    import riscv_mem_defs::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic arb_en,
    input  logic if_req,
    input  logic ls_req,
    output logic gnt_if,
    output logic gnt_ls
);

    localparam int unsigned          c_cnt_w      = starve_cnt_w(STARVE_MAX);
    localparam logic [c_cnt_w-1:0]   c_starve_max = c_cnt_w'(STARVE_MAX);

    logic [c_cnt_w-1:0] r_starve_cnt;
    logic               w_force_if;

    assign w_force_if = (r_starve_cnt == c_starve_max);

    // LS normally wins; a starved IF request overrides it
    assign gnt_ls = arb_en && ls_req && !(if_req && w_force_if);
    assign gnt_if = arb_en && if_req && !gnt_ls;

    // Counter only moves in the arbitration window. When it sits at the
    // limit with IF waiting, IF wins, so saturation falls out naturally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve_cnt <= '0;
        end else if (arb_en) begin
            if (gnt_if || !if_req) begin
                r_starve_cnt <= '0;
            end else if (gnt_ls && !w_force_if) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : unified_mem_arbiter                                              |
// | Purpose : Shares one single-ported memory bus between instruction fetch    |
// |           (IF) and load/store (LS). One transaction in flight at a time;   |
// |           responses are routed back to the owner of that transaction.      |
// | Ports   : clk, rstn                       clock / async active-low reset   |
// |           if_req/addr, if_gnt             fetch request / accept pulse     |
// |           if_rvalid/rdata                 fetch response                   |
// |           ls_req/we/addr/wdata/be, ls_gnt load/store request / accept      |
// |           ls_rvalid/rdata                 LS response (rdata 0 on store)   |
// |           bus_valid/ready/we/addr/wdata/be  bus request channel            |
// |           bus_rvalid/rdata                bus response channel             |
// |           if_busy, ls_busy                stall indications                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module unified_mem_arbiter
    import riscv_mem_defs::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                if_busy,
    output logic                ls_busy
);

    arb_state_t r_state;
    arb_owner_t r_owner;
    logic       w_arb_en;
    logic       w_gnt_if;
    logic       w_gnt_ls;

    // Grants are combinational; gating with rstn keeps them low while the
    // arbiter is held in reset even though the FSM already reads IDLE.
    assign w_arb_en = rstn && (r_state == ST_IDLE);

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk    (clk),
        .rstn   (rstn),
        .arb_en (w_arb_en),
        .if_req (if_req),
        .ls_req (ls_req),
        .gnt_if (w_gnt_if),
        .gnt_ls (w_gnt_ls)
    );

    assign if_gnt  = w_gnt_if;
    assign ls_gnt  = w_gnt_ls;

    // Owner returns to NONE when the response is delivered, so a non-NONE
    // owner means that requester has a transaction in flight.
    assign if_busy = rstn && (if_req || (r_owner == OWN_IF));
    assign ls_busy = rstn && (ls_req || (r_owner == OWN_LS));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_NONE;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_if || w_gnt_ls) begin
                        r_state   <= ST_REQ;
                        r_owner   <= w_gnt_if ? OWN_IF : OWN_LS;
                        bus_valid <= 1'b1;
                        bus_we    <= w_gnt_ls && ls_we;
                        bus_addr  <= w_gnt_if ? if_addr : ls_addr;
                        bus_wdata <= w_gnt_ls ? ls_wdata : '0;
                        bus_be    <= (w_gnt_ls && ls_we) ? ls_be : '1;
                    end
                end
                ST_REQ: begin
                    // Bus fields stay untouched until the bus accepts
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus_rvalid) begin
                        r_state <= ST_IDLE;
                        r_owner <= OWN_NONE;
                        if (r_owner == OWN_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= bus_rdata;
                        end else if (r_owner == OWN_LS) begin
                            ls_rvalid <= 1'b1;
                            // bus_we still holds the accepted request's type
                            ls_rdata  <= bus_we ? '0 : bus_rdata;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_unified_mem_arbiter                                           |
// | Purpose : Self-checking bench for unified_mem_arbiter: transaction-level   |
// |           reference model checked every cycle plus directed scenarios     |
// |           with hand-computed expectations.                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_unified_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        if_busy;
    logic        ls_busy;

    int n_tests = 0;
    int n_fail  = 0;

    unified_mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_req     (ls_req),
        .ls_we      (ls_we),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_be      (ls_be),
        .ls_gnt     (ls_gnt),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .if_busy    (if_busy),
        .ls_busy    (ls_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory responder: ready after ready_delay cycles of bus_valid,
    // response one cycle after acceptance. Data is a fixed function of
    // the address.
    // ------------------------------------------------------------------
    int          ready_delay = 0;
    bit          rsp_block   = 0;
    bit          spur        = 0;
    bit          acc_q       = 0;
    logic [31:0] acc_addr    = '0;
    int          wait_cnt    = 0;

    function automatic logic [31:0] resp_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : ~a;
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            acc_q = 0;
        end else begin
            acc_q = bus_valid && bus_ready;
            if (acc_q) acc_addr = bus_addr;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            wait_cnt   = 0;
            spur       = 0;
        end else begin
            bus_rvalid = (acc_q && !rsp_block) || spur;
            spur       = 0;
            bus_rdata  = resp_word(acc_addr);
            if (bus_valid) begin
                bus_ready = (wait_cnt >= ready_delay);
                wait_cnt++;
            end else begin
                bus_ready = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction-level reference model, checked every cycle
    // ------------------------------------------------------------------
    bit          m_on_bus = 0;   // request presented, not yet accepted
    bit          m_await  = 0;   // accepted, response not yet seen
    int          m_owner  = 0;   // 0 none, 1 IF, 2 LS
    bit          m_we     = 0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [3:0]  m_be     = '0;
    int          m_starve = 0;
    bit          e_if_rv  = 0;
    bit          e_ls_rv  = 0;
    logic [31:0] e_if_rd  = '0;
    logic [31:0] e_ls_rd  = '0;
    bit          x_free, x_gif, x_gls, x_ifb, x_lsb;

    always @(negedge clk) begin
        if (!rstn) begin
            m_on_bus = 0; m_await = 0; m_owner = 0; m_starve = 0;
            e_if_rv = 0; e_ls_rv = 0; e_if_rd = '0; e_ls_rd = '0;
        end
        x_free = rstn && !m_on_bus && !m_await;
        x_gls  = x_free && ls_req && !(if_req && m_starve >= STARVE_MAX);
        x_gif  = x_free && if_req && !x_gls;
        x_ifb  = rstn && (if_req || (m_owner == 1 && (m_on_bus || m_await)));
        x_lsb  = rstn && (ls_req || (m_owner == 2 && (m_on_bus || m_await)));

        chk("m_if_gnt",    if_gnt,    x_gif);
        chk("m_ls_gnt",    ls_gnt,    x_gls);
        chk("m_if_busy",   if_busy,   x_ifb);
        chk("m_ls_busy",   ls_busy,   x_lsb);
        chk("m_if_rvalid", if_rvalid, e_if_rv);
        chk("m_if_rdata",  if_rdata,  e_if_rd);
        chk("m_ls_rvalid", ls_rvalid, e_ls_rv);
        chk("m_ls_rdata",  ls_rdata,  e_ls_rd);
        chk("m_bus_valid", bus_valid, m_on_bus);
        if (!rstn) begin
            chk("m_rst_bus_fields", {bus_we, bus_addr, bus_wdata, bus_be}, '0);
        end else if (m_on_bus) begin
            chk("m_bus_we",   bus_we,   m_we);
            chk("m_bus_addr", bus_addr, m_addr);
            chk("m_bus_be",   bus_be,   m_be);
            if (m_we) chk("m_bus_wdata", bus_wdata, m_wdata);
        end

        // Advance to what must hold after the coming rising edge
        e_if_rv = 0;
        e_ls_rv = 0;
        if (rstn) begin
            if (x_gif || x_gls) begin
                m_owner  = x_gif ? 1 : 2;
                m_we     = x_gls && ls_we;
                m_addr   = x_gif ? if_addr : ls_addr;
                m_wdata  = ls_wdata;
                m_be     = m_we ? ls_be : 4'hF;
                m_on_bus = 1;
            end else if (m_on_bus && bus_ready) begin
                m_on_bus = 0;
                m_await  = 1;
            end else if (m_await && bus_rvalid) begin
                m_await = 0;
                if (m_owner == 1) begin
                    e_if_rv = 1; e_if_rd = bus_rdata;
                end else begin
                    e_ls_rv = 1; e_ls_rd = m_we ? 32'h0 : bus_rdata;
                end
            end
            if (x_free) begin
                if (!if_req || x_gif) m_starve = 0;
                else if (x_gls && m_starve < STARVE_MAX) m_starve++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit is_if);
        bit ok = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (is_if ? if_gnt : ls_gnt) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_rv(input bit is_if, output int cyc);
        cyc = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            cyc++;
            if (is_if ? if_rvalid : ls_rvalid) return;
        end
        chk("rvalid_timeout", 0, 1);
        cyc = -1;
    endtask

    int  cyc;
    int  nvalid;
    int  order[$];
    int  exp_order[6] = '{2, 2, 2, 2, 1, 2};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        if_req = 0; if_addr = '0;
        ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
        #1 rstn = 1'b0;

        // Reset held with a pending fetch: everything stays quiet
        if_req = 1; if_addr = 32'h100;
        repeat (3) @(negedge clk);
        chk("rst_if_gnt",    if_gnt,    0);
        chk("rst_if_busy",   if_busy,   0);
        chk("rst_bus_valid", bus_valid, 0);
        tick;
        rstn = 1'b1;
        @(negedge clk);
        chk("if_gnt_first_cycle", if_gnt, 1);
        tick;
        if_req = 0;
        wait_rv(1, cyc);
        chk("if_latency", cyc, 3);
        chk("if_rdata_0x13", if_rdata, 32'h13);

        // Store with bus_ready held off for three cycles
        ready_delay = 3;
        tick;
        ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; ls_be = 4'h3;
        wait_gnt(0);
        tick;
        ls_req = 0;
        nvalid = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (ls_rvalid) break;
            if (bus_valid) begin
                nvalid++;
                chk("st_bus_fields", {bus_we, bus_addr, bus_wdata, bus_be},
                    {1'b1, 32'h2000, 32'hDEADBEEF, 4'h3});
            end
        end
        chk("st_valid_cycles", nvalid, 4);
        chk("st_rvalid", ls_rvalid, 1);
        chk("st_rdata_zero", ls_rdata, 0);

        // Plain load, zero-wait bus
        ready_delay = 0;
        tick;
        ls_we = 0; ls_addr = 32'h3000; ls_req = 1;
        wait_gnt(0);
        tick;
        ls_req = 0;
        wait_rv(0, cyc);
        chk("ld_latency", cyc, 3);
        chk("ld_rdata", ls_rdata, 32'hFFFF_CFFF);

        // Both requesters held: starvation limit forces IF every fifth grant
        tick;
        if_req = 1; if_addr = 32'h400;
        ls_req = 1; ls_we = 0; ls_addr = 32'h500;
        for (int n = 0; n < 60 && order.size() < 6; n++) begin
            @(negedge clk);
            if (if_gnt) order.push_back(1);
            if (ls_gnt) order.push_back(2);
        end
        tick;
        if_req = 0; ls_req = 0;
        wait_rv(0, cyc);
        chk("order_len", order.size(), 6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk($sformatf("grant_order[%0d]", i), order[i], exp_order[i]);

        // Spurious bus_rvalid while idle
        tick;
        @(negedge clk);
        spur = 1;
        @(negedge clk);
        @(negedge clk);
        chk("spur_idle_if_rv", if_rvalid, 0);
        chk("spur_idle_ls_rv", ls_rvalid, 0);
        chk("spur_idle_bus_valid", bus_valid, 0);

        // Spurious bus_rvalid while the request waits for ready
        ready_delay = 2;
        tick;
        if_req = 1; if_addr = 32'h600;
        wait_gnt(1);
        spur = 1;
        tick;
        if_req = 0;
        @(negedge clk);
        chk("spur_req_bus_valid1", bus_valid, 1);
        @(negedge clk);
        chk("spur_req_if_rv", if_rvalid, 0);
        chk("spur_req_bus_valid2", bus_valid, 1);
        wait_rv(1, cyc);
        chk("spur_req_rdata", if_rdata, 32'hFFFF_F9FF);

        // Async reset while waiting for a response, LS request still pending
        ready_delay = 0;
        rsp_block   = 1;
        tick;
        ls_req = 1; ls_we = 0; ls_addr = 32'h700;
        wait_gnt(0);
        @(negedge clk);
        @(negedge clk);
        chk("resp_ls_busy", ls_busy, 1);
        tick;
        rstn = 1'b0;
        #1;
        chk("async_rst_ls_busy", ls_busy, 0);
        chk("async_rst_ls_gnt", ls_gnt, 0);
        chk("async_rst_bus", {bus_valid, bus_we, bus_addr, bus_be}, '0);
        chk("async_rst_rdata", ls_rdata, 0);
        @(negedge clk);
        rsp_block = 0;
        tick;
        rstn = 1'b1;
        @(negedge clk);
        chk("regrant_after_rst", ls_gnt, 1);
        tick;
        ls_req = 0;
        wait_rv(0, cyc);
        chk("regrant_latency", cyc, 3);
        chk("regrant_rdata", ls_rdata, 32'hFFFF_F8FF);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
